// File: rtl/vegeta_sched_pkg.sv
// Shared types and constants for the VEGETA tile scheduler: FSM state encoding,
// legal sparsity degrees and the WAIT timeout limit.
package vegeta_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_FINISH  = 3'd4
    } sched_state_e;

    localparam logic [31:0] SPARSITY_1    = 32'd1;
    localparam logic [31:0] SPARSITY_2    = 32'd2;
    localparam logic [31:0] SPARSITY_4    = 32'd4;
    localparam logic [19:0] TIMEOUT_LIMIT = 20'hFFFFF;

    function automatic logic sparsity_ok(input logic [31:0] s);
        return (s == SPARSITY_1) || (s == SPARSITY_2) || (s == SPARSITY_4);
    endfunction

    // Shift-and-add scaling by a constant stride; evaluated once per job at load.
    function automatic logic [31:0] scale_by_stride(input logic [31:0] count,
                                                    input logic [31:0] stride);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (stride[i]) acc = acc + (count << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vegeta_tile_counter.sv
// Three-level (m outer, n, k inner) wrap/carry tile counter whose base
// addresses are maintained with incremental adders only.
module vegeta_tile_counter
    import vegeta_sched_pkg::*;
#(
    parameter logic [31:0] ACT_STRIDE = 32'd64,
    parameter logic [31:0] W_STRIDE   = 32'd64,
    parameter logic [31:0] OUT_STRIDE = 32'd16,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [CNT_W-1:0] i_m_tiles,
    input  logic [CNT_W-1:0] i_n_tiles,
    input  logic [CNT_W-1:0] i_k_tiles,
    output logic [31:0]      o_act_base,
    output logic [31:0]      o_w_base,
    output logic [31:0]      o_out_base,
    output logic             o_acc_clear,
    output logic             o_last
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_m_t, r_n_t, r_k_t;
    logic [CNT_W-1:0] r_m, r_n, r_k;
    logic [31:0]      r_act, r_act_row, r_act_kstep;
    logic [31:0]      r_w, r_w_row, r_out;
    logic             w_k_wrap, w_n_wrap, w_m_wrap;

    assign w_k_wrap = (r_k == r_k_t - ONE);
    assign w_n_wrap = (r_n == r_n_t - ONE);
    assign w_m_wrap = (r_m == r_m_t - ONE);

    // k-step of act_base is N*ACT_STRIDE; w/out steps follow from the loop order:
    // a k wrap moves out_base by one tile, and an n wrap moves w_base one tile past the last k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_t <= '0; r_n_t <= '0; r_k_t <= '0;
            r_m <= '0; r_n <= '0; r_k <= '0;
            r_act <= '0; r_act_row <= '0; r_act_kstep <= '0;
            r_w <= '0; r_w_row <= '0; r_out <= '0;
        end else if (i_load) begin
            r_m_t <= i_m_tiles; r_n_t <= i_n_tiles; r_k_t <= i_k_tiles;
            r_m <= '0; r_n <= '0; r_k <= '0;
            r_act <= '0; r_act_row <= '0;
            r_act_kstep <= scale_by_stride(32'(i_n_tiles), ACT_STRIDE);
            r_w <= '0; r_w_row <= '0; r_out <= '0;
        end else if (i_step) begin
            if (!w_k_wrap) begin
                r_k   <= r_k + ONE;
                r_act <= r_act + r_act_kstep;
                r_w   <= r_w + W_STRIDE;
            end else begin
                r_k   <= '0;
                r_out <= r_out + OUT_STRIDE;
                if (!w_n_wrap) begin
                    r_n       <= r_n + ONE;
                    r_act     <= r_act_row + ACT_STRIDE;
                    r_act_row <= r_act_row + ACT_STRIDE;
                    r_w       <= r_w_row;
                end else begin
                    r_n       <= '0;
                    r_m       <= w_m_wrap ? '0 : r_m + ONE;
                    r_act     <= '0;
                    r_act_row <= '0;
                    r_w       <= r_w + W_STRIDE;
                    r_w_row   <= r_w + W_STRIDE;
                end
            end
        end
    end

    assign o_act_base  = r_act;
    assign o_w_base    = r_w;
    assign o_out_base  = r_out;
    assign o_acc_clear = (r_k == '0);
    assign o_last      = w_k_wrap && w_n_wrap && w_m_wrap;

endmodule

// File: rtl/vegeta_tile_scheduler.sv
// Job-level tile scheduler for the VEGETA accelerator: walks m/n/k tiles and
// issues one start pulse per tile. Optional WAIT timeout: VEGETA_TILE_SCHED_TIMEOUT_EN.
module vegeta_tile_scheduler
    import vegeta_sched_pkg::*;
#(
    parameter logic [31:0] ACT_STRIDE = 32'd64,
    parameter logic [31:0] W_STRIDE   = 32'd64,
    parameter logic [31:0] OUT_STRIDE = 32'd16,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_m_tiles,
    input  logic [CNT_W-1:0] cfg_n_tiles,
    input  logic [CNT_W-1:0] cfg_k_tiles,
    input  logic [31:0]      cfg_sparsity,
    input  logic             abort,
    output logic             start_multiplication,
    input  logic             compute_done,
    output logic [31:0]      sparsity_degree,
    output logic [31:0]      act_base,
    output logic [31:0]      w_base,
    output logic [31:0]      out_base,
    output logic             acc_clear,
    output logic             busy,
    output logic             job_done,
    output logic             job_err,
    output logic [2:0]       dbg_state
);
    sched_state_e r_state, w_next_state;
    logic         r_cd_prev, r_job_err;
    logic [31:0]  r_sparsity;
    logic         w_accept, w_cfg_ok, w_cd_rise, w_step, w_err_set, w_last, w_timeout;

    // cfg handshake: a job transfers on the cycle cfg_valid && cfg_ready are both high.
    assign cfg_ready = (r_state == ST_IDLE);
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_cfg_ok  = (cfg_m_tiles != '0) && (cfg_n_tiles != '0) && (cfg_k_tiles != '0)
                       && sparsity_ok(cfg_sparsity);
    assign w_cd_rise = compute_done && !r_cd_prev;

`ifdef VEGETA_TILE_SCHED_TIMEOUT_EN
    logic [19:0] r_wait_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_wait_cnt <= '0;
        else if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 20'd1;
        else                        r_wait_cnt <= '0;
    end
    assign w_timeout = (r_state == ST_WAIT) && (r_wait_cnt == TIMEOUT_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_step       = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) begin
                if (w_cfg_ok) w_next_state = ST_ISSUE;
                else          w_err_set    = 1'b1;
            end
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (w_timeout) begin
                    w_next_state = ST_IDLE;
                    w_err_set    = 1'b1;
                end else if (w_cd_rise) begin
                    w_next_state = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (w_last) w_next_state = ST_FINISH;
                else begin
                    w_next_state = ST_ISSUE;
                    w_step       = 1'b1;
                end
            end
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
        // Abort overrides everything, including a coincident compute_done edge.
        if (abort && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
            w_step       = 1'b0;
            w_err_set    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cd_prev  <= 1'b1;
            r_job_err  <= 1'b0;
            r_sparsity <= '0;
        end else begin
            r_state   <= w_next_state;
            r_cd_prev <= compute_done;
            r_job_err <= w_err_set;
            if (w_accept) r_sparsity <= cfg_sparsity;
        end
    end

    vegeta_tile_counter #(
        .ACT_STRIDE (ACT_STRIDE),
        .W_STRIDE   (W_STRIDE),
        .OUT_STRIDE (OUT_STRIDE),
        .CNT_W      (CNT_W)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_step      (w_step),
        .i_m_tiles   (cfg_m_tiles),
        .i_n_tiles   (cfg_n_tiles),
        .i_k_tiles   (cfg_k_tiles),
        .o_act_base  (act_base),
        .o_w_base    (w_base),
        .o_out_base  (out_base),
        .o_acc_clear (acc_clear),
        .o_last      (w_last)
    );

    assign start_multiplication = (r_state == ST_ISSUE);
    assign job_done             = (r_state == ST_FINISH);
    assign busy                 = (r_state != ST_IDLE);
    assign job_err              = r_job_err;
    assign sparsity_degree      = r_sparsity;
    assign dbg_state            = r_state;

endmodule
